// File: rtl/audio_pkg.sv
// Shared definitions for the sound generators and the speaker arbiter:
// state encoding, default sound durations at 50 MHz, and a small helper.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENGINE = 2'd1,
    ST_CRASH  = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int unsigned CRASH_CYCLES_DEF = 25_000_000;
  localparam int unsigned OVER_CYCLES_DEF  = 200_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audio_timer.sv
// Loadable down-counter shared by the timed sounds; expire is a registered
// flag that is high exactly while the count equals 1.
module audio_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (en && (count != '0)) begin
      count_next = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else begin
      count  <= count_next;
      expire <= (count_next == W'(1));
    end
  end

endmodule

// File: rtl/audio_arbiter.sv
// Selects which sound generator drives the speaker (game-over > crash > engine)
// with timed crash/game-over playback. Optional volume gating: AUDIO_ARB_VOLUME_EN.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned CRASH_CYCLES = CRASH_CYCLES_DEF,
  parameter int unsigned OVER_CYCLES  = OVER_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_en,
  input  logic       crash_trig,
  input  logic       game_over,
  input  logic       mute,
  input  logic       engine_pwm,
  input  logic       crash_pwm,
  input  logic       gameover_pwm,
`ifdef AUDIO_ARB_VOLUME_EN
  input  logic [2:0] vol,
`endif
  output logic       spk,
  output logic [1:0] state,
  output logic       busy
);

  localparam int unsigned TW = $clog2(max_u(CRASH_CYCLES, OVER_CYCLES) + 1);

  state_t        cur;
  state_t        nxt;
  logic          over_done;
  logic          done_nxt;
  logic          load;
  logic          en;
  logic [TW-1:0] load_val;
  logic          expire;
  logic          src;
  logic          gate;

  audio_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .expire  (expire)
  );

  // Timer controls and next state share one decision tree so reload/decrement
  // always agree with the transition taken.
  always_comb begin
    nxt      = cur;
    done_nxt = over_done;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    unique case (cur)
      ST_IDLE, ST_ENGINE: begin
        if (game_over) begin
          nxt      = ST_OVER;
          done_nxt = 1'b0;
          load     = 1'b1;
          load_val = TW'(OVER_CYCLES);
        end else if (crash_trig) begin
          nxt      = ST_CRASH;
          load     = 1'b1;
          load_val = TW'(CRASH_CYCLES);
        end else begin
          nxt = engine_en ? ST_ENGINE : ST_IDLE;
        end
      end
      ST_CRASH: begin
        if (game_over) begin
          nxt      = ST_OVER;
          done_nxt = 1'b0;
          load     = 1'b1;
          load_val = TW'(OVER_CYCLES);
        end else if (crash_trig) begin
          load     = 1'b1;
          load_val = TW'(CRASH_CYCLES);
        end else if (expire) begin
          nxt = engine_en ? ST_ENGINE : ST_IDLE;
        end else begin
          en = 1'b1;
        end
      end
      ST_OVER: begin
        if (!game_over) begin
          nxt      = ST_IDLE;
          done_nxt = 1'b0;
        end else if (!over_done) begin
          if (expire) begin
            done_nxt = 1'b1;
          end else begin
            en = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    src = 1'b0;
    unique case (cur)
      ST_IDLE:   src = 1'b0;
      ST_ENGINE: src = engine_pwm;
      ST_CRASH:  src = crash_pwm;
      ST_OVER:   src = gameover_pwm & ~over_done;
    endcase
  end

`ifdef AUDIO_ARB_VOLUME_EN
  logic [2:0] phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else begin
      phase <= phase + 3'd1;
    end
  end

  assign gate = ~mute & (phase < vol);
`else
  assign gate = ~mute;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= ST_IDLE;
      over_done <= 1'b0;
      spk       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur       <= nxt;
      over_done <= done_nxt;
      spk       <= src & gate;
      busy      <= (nxt == ST_CRASH) | ((nxt == ST_OVER) & ~done_nxt);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: directed scenarios plus random
// stimulus, checked every cycle against a cycle-count model of the rules.
module tb_audio_arbiter;

  localparam int CRASH = 10;
  localparam int OVER  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       engine_en = 1'b0;
  logic       crash_trig = 1'b0;
  logic       game_over = 1'b0;
  logic       mute = 1'b0;
  logic       engine_pwm = 1'b0;
  logic       crash_pwm = 1'b0;
  logic       gameover_pwm = 1'b0;
`ifdef AUDIO_ARB_VOLUME_EN
  logic [2:0] vol = 3'd7;
`endif
  logic       spk;
  logic [1:0] state;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit eng_const = 1'b0;

  audio_arbiter #(
    .CRASH_CYCLES(CRASH),
    .OVER_CYCLES (OVER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .engine_en   (engine_en),
    .crash_trig  (crash_trig),
    .game_over   (game_over),
    .mute        (mute),
    .engine_pwm  (engine_pwm),
    .crash_pwm   (crash_pwm),
    .gameover_pwm(gameover_pwm),
`ifdef AUDIO_ARB_VOLUME_EN
    .vol         (vol),
`endif
    .spk         (spk),
    .state       (state),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source PWMs: engine toggles, crash has period 3, game-over is random.
  always @(negedge clk) begin
    cyc++;
    engine_pwm   = eng_const ? 1'b1 : cyc[0];
    crash_pwm    = (cyc % 3 == 0);
    gameover_pwm = 1'($urandom_range(0, 1));
  end

  // Behavioural model: mode plus "cycles left" counters, updated per edge.
  int m_st = 0, m_left = 0, m_done = 0, m_spk = 0, m_busy = 0, m_phase = 0;

  always @(posedge clk) begin
    int r, go, ct, ee, mu, ep, cp, gp, s, g;
    int v;
    r = rst; go = game_over; ct = crash_trig; ee = engine_en; mu = mute;
    ep = engine_pwm; cp = crash_pwm; gp = gameover_pwm;
    v = 8;
`ifdef AUDIO_ARB_VOLUME_EN
    v = int'(vol);
`endif
    if (r != 0) begin
      m_st = 0; m_left = 0; m_done = 0; m_spk = 0; m_busy = 0; m_phase = 0;
    end else begin
      case (m_st)
        1: s = ep;
        2: s = cp;
        3: s = (m_done != 0) ? 0 : gp;
        default: s = 0;
      endcase
      g = (mu == 0) && (m_phase < v);
      m_spk = s & g;
      m_phase = (m_phase + 1) % 8;
      case (m_st)
        0, 1: begin
          if (go != 0) begin m_st = 3; m_left = OVER; m_done = 0; end
          else if (ct != 0) begin m_st = 2; m_left = CRASH; end
          else m_st = (ee != 0) ? 1 : 0;
        end
        2: begin
          if (go != 0) begin m_st = 3; m_left = OVER; m_done = 0; end
          else if (ct != 0) m_left = CRASH;
          else if (m_left == 1) m_st = (ee != 0) ? 1 : 0;
          else m_left--;
        end
        default: begin
          if (go == 0) begin m_st = 0; m_done = 0; end
          else if (m_done == 0) begin
            if (m_left == 1) m_done = 1;
            else m_left--;
          end
        end
      endcase
      m_busy = (m_st == 2) || (m_st == 3 && m_done == 0);
    end
    #1;
    check("state", int'(state), m_st);
    check("busy", int'(busy), m_busy);
    check("spk", int'(spk), m_spk);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_state(input int s, output int n);
    n = 0;
    while (n < 200 && int'(state) == s) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (n < 200 && busy == 1'b1) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int cnt;
    repeat (3) tick();
    check("lit_rst_state", int'(state), 0);
    check("lit_rst_spk", int'(spk), 0);
    check("lit_rst_busy", int'(busy), 0);
    rst = 1'b0;
    engine_en = 1'b1;
    repeat (2) tick();
    check("lit_engine_state", int'(state), 1);
    check("lit_engine_busy", int'(busy), 0);
    repeat (4) tick();

    // single crash
    crash_trig = 1'b1; tick(); crash_trig = 1'b0;
    check("lit_crash_busy", int'(busy), 1);
    run_state(2, n);
    check("lit_crash_len", n, 10);
    check("lit_crash_exit_state", int'(state), 1);
    check("lit_crash_exit_busy", int'(busy), 0);
    repeat (3) tick();

    // retrigger after 6 cycles, engine dropped -> exit to idle
    crash_trig = 1'b1; tick(); crash_trig = 1'b0;
    repeat (5) tick();
    crash_trig = 1'b1; engine_en = 1'b0; tick(); crash_trig = 1'b0;
    check("lit_retrig_state", int'(state), 2);
    run_state(2, n);
    check("lit_retrig_len", n + 6, 16);
    check("lit_retrig_exit_state", int'(state), 0);
    tick();
    check("lit_retrig_spk", int'(spk), 0);

    // game-over beats simultaneous crash
    engine_en = 1'b1; tick();
    crash_trig = 1'b1; game_over = 1'b1; tick(); crash_trig = 1'b0;
    check("lit_over_state", int'(state), 3);
    check("lit_over_busy", int'(busy), 1);
    run_busy(n);
    check("lit_over_len", n, 20);
    check("lit_over_hold_state", int'(state), 3);
    tick();
    check("lit_over_done_spk", int'(spk), 0);
    check("lit_over_done_busy", int'(busy), 0);
    game_over = 1'b0; tick();
    check("lit_over_exit_state", int'(state), 0);

    // mute during crash keeps timing
    tick();
    crash_trig = 1'b1; mute = 1'b1; tick(); crash_trig = 1'b0;
    run_state(2, n);
    check("lit_mute_len", n, 10);
    check("lit_mute_exit_state", int'(state), 1);
    mute = 1'b0;

    // reset mid game-over
    game_over = 1'b1; tick();
    repeat (4) tick();
    rst = 1'b1; tick();
    check("lit_midrst_state", int'(state), 0);
    check("lit_midrst_spk", int'(spk), 0);
    check("lit_midrst_busy", int'(busy), 0);
    rst = 1'b0; game_over = 1'b0; tick();

`ifdef AUDIO_ARB_VOLUME_EN
    eng_const = 1'b1; engine_en = 1'b1; vol = 3'd2;
    repeat (4) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cnt += int'(spk); tick(); end
    check("lit_vol2_count", cnt, 4);
    vol = 3'd0;
    repeat (2) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cnt += int'(spk); tick(); end
    check("lit_vol0_count", cnt, 0);
    vol = 3'd7; eng_const = 1'b0;
`else
    cnt = 0;
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      crash_trig = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) game_over = ~game_over;
      if ($urandom_range(0, 39) == 0) engine_en = ~engine_en;
      if ($urandom_range(0, 49) == 0) mute = ~mute;
`ifdef AUDIO_ARB_VOLUME_EN
      if ($urandom_range(0, 99) == 0) vol = 3'($urandom_range(0, 7));
`endif
      tick();
    end
    rst = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_arbiter.md
# audio_arbiter

Downstream stage of the game's sound generators. Takes the 1-bit PWM outputs of the engine, crash and game-over sound modules, and selects which one drives the single speaker pin based on game events. Priority order is game-over > crash > engine. A timed state machine bounds how long the crash and game-over sounds play. The registered speaker output goes straight to the board's audio pin.

## Interface
Parameters:
- CRASH_CYCLES, 25_000_000: clock cycles the crash sound plays per trigger (0.5 s at 50 MHz); must be ≥1.
- OVER_CYCLES, 200_000_000: clock cycles the game-over sound plays (4 s at 50 MHz); must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- engine_en  in  1  level; race running, engine sound wanted.
- crash_trig  in  1  one-cycle pulse per collision.
- game_over  in  1  level; held high while the game-over screen is shown.
- mute  in  1  level; forces the speaker silent without affecting state.
- engine_pwm  in  1  engine sound PWM.
- crash_pwm  in  1  crash sound PWM.
- gameover_pwm  in  1  game-over sound PWM.
- spk  out  1  registered speaker PWM.
- state  out  2  current state encoding: 0 IDLE, 1 ENGINE, 2 CRASH, 3 OVER.
- busy  out  1  high while a timed sound (CRASH, or OVER not yet expired) is playing.

## Operation
- One down-counter `timer`, width $clog2(max(CRASH_CYCLES, OVER_CYCLES)+1), shared by the CRASH and OVER states.
- One flag `over_done` marks that the OVER sound has expired.
- State transitions are evaluated every cycle. Within a cycle, the first matching rule wins in listed order.
- IDLE: game_over → OVER (timer=OVER_CYCLES, over_done=0). Otherwise crash_trig → CRASH (timer=CRASH_CYCLES). Otherwise engine_en → ENGINE.
- ENGINE: game_over → OVER. Otherwise crash_trig → CRASH. Otherwise !engine_en → IDLE.
- CRASH: game_over → OVER. Otherwise crash_trig reloads timer=CRASH_CYCLES and stays in CRASH (retrigger). Otherwise, when timer==1, leave to ENGINE if engine_en, else IDLE. Otherwise timer decrements.
- OVER: !game_over → IDLE (over_done cleared). Otherwise, if !over_done: at timer==1 set over_done, else decrement timer. crash_trig and engine_en are ignored in OVER.
- Source selection by state (next-cycle value of spk):
  - IDLE: 0.
  - ENGINE: engine_pwm.
  - CRASH: crash_pwm.
  - OVER: gameover_pwm while !over_done, 0 once over_done is set.
- mute=1 forces spk to 0. State and timers continue unaffected.
- busy = (state==CRASH) | (state==OVER & !over_done), registered together with state.

## Timing
- Reset values: state=IDLE, spk=0, busy=0, timer=0, over_done=0. Reset mid-sound aborts immediately; spk is 0 on the cycle after rst is sampled high.
- Latency: spk reflects the selected source input sampled one edge earlier (1-cycle registered path). State change on edge N means the new source appears on spk after edge N+1.
- CRASH duration is exactly CRASH_CYCLES cycles in CRASH state, counted from the entry/reload edge, absent retrigger or game_over.
- OVER sound lasts exactly OVER_CYCLES cycles. spk returns to 0 one cycle after over_done is set.
- Simultaneous crash_trig and game_over: game_over wins.
- crash_trig on the same cycle as timer==1 in CRASH: reload wins.
- game_over deasserting on the same cycle as OVER expiry: go to IDLE.

## Configuration
- AUDIO_ARB_VOLUME_EN defined:
  - Adds input `vol` (3 bits) and a free-running 3-bit phase counter (reset 0, increments every cycle, wraps 7→0).
  - Pre-register spk term is ANDed with (phase < vol). vol=0 gives silence; vol=7 gives 7/8 duty gating.
- Macro undefined: no vol port, no phase counter; full volume behaviour as above.

## Structure
- Shared package `audio_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_ENGINE=2'd1, ST_CRASH=2'd2, ST_OVER=2'd3.
  - Default CRASH_CYCLES/OVER_CYCLES constants at 50 MHz.
  - Used by the sound modules and the top level.
- One sub-module, `audio_timer`: loadable down-counter with `load`, `load_val`, `en`, and a registered `expire` flag at count==1. Instantiated once.

## Test plan
Bench parameters: CRASH_CYCLES=10, OVER_CYCLES=20, source PWMs driven as distinct patterns.

- **Reset and engine selection:** rst high 3 cycles, then engine_en=1 → state=1 two edges after rst low; spk tracks engine_pwm with 1-cycle delay; busy=0.
- **Single crash:** crash_trig pulse in ENGINE → state=2 for exactly 10 cycles, busy=1, spk=crash_pwm; then state=1, busy=0.
- **Crash retrigger:** second crash_trig 6 cycles after the first → CRASH lasts 16 cycles total. With engine_en dropped during CRASH → exit to IDLE, spk=0.
- **Game-over priority:** crash_trig and game_over in the same cycle → state=3, spk=gameover_pwm for 20 cycles, then spk=0 and busy=0 while state stays 3. game_over low → IDLE next edge.
- **Mute and mid-sound reset:** mute=1 during CRASH → spk=0 while state/timer continue and exit still occurs at 10 cycles. rst pulse at OVER cycle 5 → state=0, spk=0, busy=0 next edge.
- **Volume gating (AUDIO_ARB_VOLUME_EN):** vol=2 with engine_pwm=1 constant → spk high on exactly 2 of every 8 cycles. vol=0 → spk stays 0.
